// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the MMU memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  // RISC-V load/store funct3 size encodings
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return (((size == SZ_H) || (size == SZ_HU)) && addr_lo[0]) ||
           ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

  function automatic logic size_valid(input logic [2:0] size);
    return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
           (size == SZ_BU) || (size == SZ_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and size/sign extension for loads.
module mem_lane_align
  import mem_resp_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store side: replicate the low bits across lanes, enable only the addressed ones
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B, SZ_BU: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load side: bring the addressed bytes to lane 0, then extend
  always_comb begin
    shifted = rword_i >> {addr_lo_i, 3'b000};
    rdata_o = shifted;
    case (size_i)
      SZ_B:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      SZ_BU: rdata_o = {24'h0, shifted[7:0]};
      SZ_H:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      SZ_HU: rdata_o = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mmu_mem_responder.sv
// Single-outstanding memory responder with programmable latency for the MMU.
module mmu_mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_ADDR_WIDTH = 17,
  parameter int unsigned LATENCY        = 2,
  parameter string       INIT_FILE      = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [2:0]            mem_size,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
  output logic                  mem_err,
  output logic                  busy
);

  localparam int unsigned NumWords = 2 ** (MEM_ADDR_WIDTH - 2);
  localparam logic [3:0]  LatInit  = 4'(LATENCY - 1);

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [MEM_ADDR_WIDTH-1:0] addr_q, acc_addr;
  logic [2:0]                size_q, acc_size;
  logic [31:0]               wdata_q, acc_wdata;
  logic                      write_q, acc_write;
  logic                      err_q, acc_err, req_err;
  logic [31:0]               rdata_q;
  logic                      accept, enter_resp;
  logic [3:0]                be;
  logic [31:0]               wdata_lane, rword, load_data;
  logic [31:0]               store [NumWords];

  assign req_err = (mem_read && mem_write) ||
                   is_misaligned(mem_size, mem_addr[1:0]) ||
                   !size_valid(mem_size) ||
                   ((mem_addr >> MEM_ADDR_WIDTH) != '0);

  // With LATENCY=1 the access happens on the accept edge, so use live inputs then
  assign acc_addr  = accept ? mem_addr[MEM_ADDR_WIDTH-1:0] : addr_q;
  assign acc_size  = accept ? mem_size : size_q;
  assign acc_wdata = accept ? mem_wdata : wdata_q;
  assign acc_write = accept ? mem_write : write_q;
  assign acc_err   = accept ? req_err : err_q;

  assign rword = store[acc_addr[MEM_ADDR_WIDTH-1:2]];

  mem_lane_align u_lane_align (
    .size_i    (acc_size),
    .addr_lo_i (acc_addr[1:0]),
    .wdata_i   (acc_wdata),
    .rword_i   (rword),
    .be_o      (be),
    .wdata_o   (wdata_lane),
    .rdata_o   (load_data)
  );

  // Next-state: accept only from idle, count down the latency, pulse one response cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_read || mem_write) begin
          accept = 1'b1;
          cnt_d  = LatInit;
          if (LATENCY > 1) begin
            state_d = StWait;
          end else begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, counter, request latch and registered load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= mem_addr[MEM_ADDR_WIDTH-1:0];
        size_q  <= mem_size;
        wdata_q <= mem_wdata;
        write_q <= mem_write;
        err_q   <= req_err;
      end
      if (enter_resp) begin
        rdata_q <= (acc_err || acc_write) ? 32'h0 : load_data;
      end
    end
  end

  // Byte-lane store commit on the edge entering the response; never while in reset
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && acc_write && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) store[acc_addr[MEM_ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == StResp);
  assign mem_err   = mem_ready && err_q;
  // Covers the accepting idle cycle as well as wait/response
  assign busy      = rst_n && ((state_q != StIdle) || mem_read || mem_write);

endmodule
